// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU with single-cycle ops and an optional shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the multi-cycle multiply (op 4'b0110) and its MUL state.
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal
);
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b0110;
    localparam logic [3:0] OP_LUI  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0011;

    logic [WIDTH-1:0] r_result, w_res, w_mul_res;
    logic             r_zero, r_done, r_illegal;
    logic             w_sup, w_idle, w_go_mul, w_mul_done;

    always_comb begin
        w_res = (alucontrol == OP_ADD)  ? a + b :
                (alucontrol == OP_PASS) ? a :
                (alucontrol == OP_LUI)  ? b << 16 :
                (alucontrol == OP_OR)   ? a | b : '0;
        w_sup = (alucontrol == OP_ADD) || (alucontrol == OP_PASS) ||
                (alucontrol == OP_LUI) || (alucontrol == OP_OR);
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic {IDLE, MUL} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_ma, r_mb, r_acc;
    logic [CW-1:0]    r_cnt;

    assign w_idle     = (r_state == IDLE);
    assign w_go_mul   = w_idle && start && (alucontrol == OP_MUL);
    assign w_mul_done = (r_state == MUL) && (r_cnt == CW'(WIDTH - 1));
    assign w_mul_res  = r_acc + (r_mb[0] ? r_ma : '0);
    assign busy       = (r_state == MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_go_mul)        w_next = MUL;
        else if (w_mul_done) w_next = IDLE;
    end

    // One shift-add step per edge on the captured operand copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ma  <= '0;
            r_mb  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_go_mul) begin
            r_ma  <= a;
            r_mb  <= b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (busy) begin
            r_ma  <= r_ma << 1;
            r_mb  <= r_mb >> 1;
            r_acc <= w_mul_res;
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_idle     = 1'b1;
    assign w_go_mul   = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_res  = '0;
    assign busy       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_idle && start && !w_go_mul) begin
                r_result  <= w_res;
                r_zero    <= (w_res == '0);
                r_illegal <= !w_sup;
                r_done    <= 1'b1;
            end else if (w_mul_done) begin
                r_result  <= w_mul_res;
                r_zero    <= (w_mul_res == '0);
                r_illegal <= 1'b0;
                r_done    <= 1'b1;
            end
        end
    end

    assign result  = r_result;
    assign zero    = r_zero;
    assign done    = r_done;
    assign illegal = r_illegal;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed self-checking bench for alu_seq_unit.
// Multiplier scenarios run when ALU_SEQ_MUL_EN is defined, the disabled-op scenario otherwise.
module tb_alu_seq_unit;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
    logic             illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .alucontrol(alucontrol),
        .a         (a),
        .b         (b),
        .result    (result),
        .zero      (zero),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal)
    );

    task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start      = 1'b1;
        alucontrol = op;
        a          = va;
        b          = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want %h", result, 32'h0); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", zero); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    endtask

    // First start is driven together with reset release so the first edge must accept it.
    task automatic test_add();
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; alucontrol = 4'b0010; a = 32'd5; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++; if (result !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h want %h", result, 32'd12); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b want 0", zero); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b want 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy: got %b want 0", busy); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", done); end
        n_checks++; if (result !== 32'd12) begin n_fail++; $display("FAIL add_hold: got %h want %h", result, 32'd12); end
        issue(4'b0010, 32'hFFFF_FFFF, 32'h1);
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL add_wrap_result: got %h want %h", result, 32'h0); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL add_wrap_zero: got %b want 1", zero); end
    endtask

    task automatic test_lui_or_pass();
        issue(4'b0000, 32'hAAAA_AAAA, 32'h0000_1234);
        n_checks++; if (result !== 32'h1234_0000) begin n_fail++; $display("FAIL lui_result: got %h want %h", result, 32'h1234_0000); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL lui_zero: got %b want 0", zero); end
        issue(4'b0011, 32'h0000_00F0, 32'h0000_000F);
        n_checks++; if (result !== 32'h0000_00FF) begin n_fail++; $display("FAIL or_result: got %h want %h", result, 32'h0000_00FF); end
        issue(4'b0111, 32'hDEAD_BEEF, 32'h1111_1111);
        n_checks++; if (result !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pass_result: got %h want %h", result, 32'hDEAD_BEEF); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL pass_illegal: got %b want 0", illegal); end
    endtask

    task automatic test_illegal();
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL illegal_result: got %h want %h", result, 32'h0); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL illegal_zero: got %b want 1", zero); end
        n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b want 1", illegal); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL illegal_done: got %b want 1", done); end
        @(posedge clk);
        #1;
        n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_hold: got %b want 1", illegal); end
        issue(4'b0011, 32'h1, 32'h2);
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_clear: got %b want 0", illegal); end
        n_checks++; if (result !== 32'h3) begin n_fail++; $display("FAIL illegal_clear_result: got %h want %h", result, 32'h3); end
    endtask

    task automatic test_back_to_back();
        issue(4'b0010, 32'd1, 32'd2);
        start = 1'b1; alucontrol = 4'b0011; a = 32'h8; b = 32'h4;
        n_checks++; if (result !== 32'd3) begin n_fail++; $display("FAIL b2b_first: got %h want %h", result, 32'd3); end
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++; if (result !== 32'hC) begin n_fail++; $display("FAIL b2b_second: got %h want %h", result, 32'hC); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", done); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_end: got %b want 0", done); end
    endtask

    task automatic test_async_reset();
        issue(4'b0001, 32'h0, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL arst_illegal: got %b want 0", illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'b0010, 32'd5, 32'd7);
        rst_n = 1'b0;
        #1;
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL arst_result: got %h want %h", result, 32'h0); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL arst_zero: got %b want 1", zero); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %b want 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_mul();
        int busy_cnt;
        int done_cnt;
        logic [31:0] got;
        busy_cnt = 0; done_cnt = 0; got = 32'h0;
        issue(4'b0110, 32'hFFFF_FFFF, 32'h2);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy_start: got %b want 1", busy); end
        if (busy) busy_cnt++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; got = result; end
        end
        n_checks++; if (busy_cnt !== 32) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 32", busy_cnt); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL mul_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (got !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_result: got %h want %h", got, 32'hFFFF_FFFE); end
    endtask

    task automatic test_mul_ignore_start();
        int done_cnt;
        logic [31:0] got;
        done_cnt = 0; got = 32'h0;
        issue(4'b0110, 32'd3, 32'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; alucontrol = 4'b0010; a = 32'd100; b = 32'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin done_cnt++; got = result; end
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL mul_ign_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (got !== 32'd15) begin n_fail++; $display("FAIL mul_ign_result: got %h want %h", got, 32'd15); end
    endtask

    task automatic test_mul_reset();
        int done_cnt;
        done_cnt = 0;
        issue(4'b0110, 32'd7, 32'd9);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL mul_rst_result: got %h want %h", result, 32'h0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_rst_busy: got %b want 0", busy); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL mul_rst_zero: got %b want 1", zero); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL mul_rst_no_done: got %0d want 0", done_cnt); end
        issue(4'b0001, 32'h5, 32'h6);
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL mul_rst_op1_result: got %h want %h", result, 32'h0); end
        n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL mul_rst_op1_illegal: got %b want 1", illegal); end
    endtask
`else
    task automatic test_mul_disabled();
        int busy_cnt;
        busy_cnt = 0;
        issue(4'b0011, 32'h10, 32'h1);
        issue(4'b0110, 32'd3, 32'd4);
        if (busy) busy_cnt++;
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL nomul_result: got %h want %h", result, 32'h0); end
        n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL nomul_illegal: got %b want 1", illegal); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL nomul_done: got %b want 1", done); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL nomul_zero: got %b want 1", zero); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
        end
        n_checks++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL nomul_busy: got %0d want 0", busy_cnt); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; alucontrol = 4'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_add();
        test_lui_or_pass();
        test_illegal();
        test_back_to_back();
        test_async_reset();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
        test_mul_ignore_start();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 alucontrol  input  4  operation code from ALU control stage.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 result  output  WIDTH  registered result of last completed operation.
REQ-009 zero  output  1  registered; high when result equals 0.
REQ-010 busy  output  1  high while a multi-cycle operation is in progress.
REQ-011 done  output  1  one-cycle pulse on completion.
REQ-012 illegal  output  1  registered; high when the last completed op code was unsupported.

Function
REQ-013 Op codes: 4'b0010 add (a+b, modulo 2^WIDTH); 4'b0111 pass (result=a, jump-register target); 4'b0110 multiply (low WIDTH bits of a*b, unsigned); 4'b0000 lui (b<<16, low bits zero); 4'b0011 or (a|b).
REQ-014 States: IDLE, MUL; no other states.
REQ-015 IDLE with start=1 and single-cycle op: a, b, alucontrol captured at edge E0; result, zero, illegal updated and done=1 in the cycle after E0; state stays IDLE.
REQ-016 IDLE with start=1 and alucontrol=4'b0110: operands captured at E0, state->MUL, busy=1 from E0.
REQ-017 MUL performs one shift-add iteration per edge E1..E32 (WIDTH iterations); at E_WIDTH result, zero updated, done=1, busy=0, state->IDLE.
REQ-018 start while busy=1 is ignored; inputs a, b, alucontrol ignored during MUL (captured copies used).
REQ-019 done is high for exactly one cycle per accepted start; start asserted during the done cycle is accepted (state is IDLE).
REQ-020 Unsupported op code (any value not in REQ-013): completes as single-cycle, result=0, zero=1, illegal=1, done=1.
REQ-021 illegal cleared to 0 on completion of any supported op.
REQ-022 result, zero, illegal hold their values between completions.

Reset
REQ-023 rst_n low forces, asynchronously: state=IDLE, result=0, zero=1, busy=0, done=0, illegal=0, internal operand/accumulator/counter registers=0.
REQ-024 Reset during MUL aborts the operation; no done pulse is produced for it.
REQ-025 First start is accepted on the first rising edge with rst_n high.

Configuration
REQ-026 Macro ALU_SEQ_MUL_EN: defined -> multiplier and MUL state compiled in, behaviour per REQ-016/017.
REQ-027 ALU_SEQ_MUL_EN undefined -> no multiplier hardware, MUL state absent; 4'b0110 treated as unsupported per REQ-020; busy is constant 0.

Verification
REQ-028 start, op 0010, a=5, b=7 -> next cycle result=12, zero=0, done=1, busy=0.
REQ-029 start, op 0110, a=32'hFFFF_FFFF, b=2 (macro on) -> busy=1 for 32 cycles, then result=32'hFFFF_FFFE, done=1 once.
REQ-030 start, op 0000, b=32'h0000_1234 -> result=32'h1234_0000; then op 0011, a=32'hF0, b=32'h0F -> result=32'hFF.
REQ-031 During mul, pulse start with op 0010 -> ignored; mul result unaffected, single done pulse.
REQ-032 rst_n low at cycle 10 of a mul -> outputs at reset values immediately, no done; op 0001 afterwards -> result=0, zero=1, illegal=1.
REQ-033 Macro off, op 0110, a=3, b=4 -> next cycle result=0, illegal=1, done=1, busy never high.
